// File: rtl/wave_pkg.sv
// Shared types for the waveform capture block: FSM states, trigger modes, default width.
// Pure declarations; no logic, no latency.
package wave_pkg;

  localparam int CNT_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_READOUT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    TRIG_IMM     = 2'd0,
    TRIG_RISE    = 2'd1,
    TRIG_FALL    = 2'd2,
    TRIG_IMM_ALT = 2'd3
  } trig_mode_e;

  // prev_ge/cur_ge are the unsigned compares against the threshold
  function automatic logic trig_hit(input trig_mode_e mode, input logic prev_vld,
                                    input logic prev_ge, input logic cur_ge);
    case (mode)
      TRIG_RISE: return prev_vld && !prev_ge && cur_ge;
      TRIG_FALL: return prev_vld && prev_ge && !cur_ge;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/wave_capture_ram.sv
// Capture buffer: simple dual-port RAM, one write port, registered read port, no array reset.
// Read data appears one cycle after i_re and holds while i_re is low.
module wave_capture_ram
  import wave_pkg::*;
#(
  parameter int DW = CNT_DEF,
  parameter int AW = CNT_DEF + 1
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/wave_capture.sv
// Triggered waveform capture: arm, wait for trigger, store 2**AW samples, stream them out.
// Readout: first word 1 cycle after entering READOUT, then 1 word/cycle; rd_ready low stalls output.
module wave_capture
  import wave_pkg::*;
#(
  parameter int CNT = CNT_DEF,
  parameter int AW  = CNT + 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_arm,
  input  logic           i_abort,
  input  logic [1:0]     i_trig_mode,
  input  logic [CNT-1:0] i_trig_level,
  input  logic           i_in_valid,
  input  logic [CNT-1:0] i_in_data,
  input  logic           i_rd_ready,
  output logic           o_rd_valid,
  output logic [CNT-1:0] o_rd_data,
  output logic           o_rd_last,
  output logic           o_busy,
  output logic           o_done
);

  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  state_e         r_state;
  logic [AW-1:0]  r_wr_ptr;
  logic [AW:0]    r_rd_ptr;
  logic [CNT-1:0] r_prev;
  logic           r_prev_vld;
  logic           r_rd_valid;
  logic           r_rd_last;
  logic           r_done;

  logic           w_trig;
  logic           w_we;
  logic [AW-1:0]  w_waddr;
  logic           w_fire;
  logic           w_issue;
  logic [CNT-1:0] w_ram_q;

  assign w_trig  = trig_hit(trig_mode_e'(i_trig_mode), r_prev_vld,
                            r_prev >= i_trig_level, i_in_data >= i_trig_level);
  assign w_we    = i_in_valid && !i_abort &&
                   ((r_state == ST_ARMED && w_trig) || r_state == ST_CAPTURE);
  assign w_waddr = (r_state == ST_ARMED) ? '0 : r_wr_ptr;
  assign w_fire  = r_rd_valid && i_rd_ready;
  // Fetch the next word whenever the output slot is empty or being drained this cycle;
  // r_rd_ptr[AW] marks that every address has already been fetched.
  assign w_issue = (r_state == ST_READOUT) && !r_rd_ptr[AW] && !i_abort &&
                   (!r_rd_valid || i_rd_ready);

  wave_capture_ram #(.DW(CNT), .AW(AW)) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (i_in_data),
    .i_re    (w_issue),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_abort) begin
        r_state    <= ST_IDLE;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_prev_vld <= 1'b0;
        r_rd_valid <= 1'b0;
        r_rd_last  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_arm) begin
              r_state    <= ST_ARMED;
              r_prev_vld <= 1'b0;
            end
          end
          ST_ARMED: begin
            if (i_in_valid) begin
              r_prev     <= i_in_data;
              r_prev_vld <= 1'b1;
              if (w_trig) begin
                r_wr_ptr <= AW'(1);
                r_state  <= ST_CAPTURE;
              end
            end
          end
          ST_CAPTURE: begin
            if (i_in_valid) begin
              if (r_wr_ptr == LAST_ADDR) begin
                r_state  <= ST_READOUT;
                r_rd_ptr <= '0;
              end else begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
              end
            end
          end
          ST_READOUT: begin
            if (w_issue) begin
              r_rd_ptr   <= r_rd_ptr + 1'b1;
              r_rd_valid <= 1'b1;
              r_rd_last  <= (r_rd_ptr[AW-1:0] == LAST_ADDR);
            end else if (w_fire) begin
              r_rd_valid <= 1'b0;
              r_rd_last  <= 1'b0;
            end
            if (w_fire && r_rd_last) begin
              r_state  <= ST_IDLE;
              r_wr_ptr <= '0;
              r_done   <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_valid ? w_ram_q : '0;
  assign o_rd_last  = r_rd_last;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = r_done;

endmodule

// File: tb/tb_wave_capture.sv
// Bench for wave_capture: random/directed captures checked against a queue-based model
// of the trigger rules and the expected readout sequence.
module tb_wave_capture;

  localparam int DEEP = 512;

  logic       clk = 1'b0;
  logic       rst, arm, abort, in_valid, rd_ready;
  logic [1:0] trig_mode;
  logic [7:0] trig_level, in_data;
  logic       rd_valid, rd_last, busy, done;
  logic [7:0] rd_data;

  int n_vec = 0;
  int n_err = 0;

  // model: phase 0 idle, 1 waiting for trigger, 2 filling, 3 draining
  int         m_phase = 0;
  bit         m_prev_vld = 0;
  logic [7:0] m_prev = 8'h00;
  logic [7:0] exp_q[$];
  logic [7:0] got0, got1;

  wave_capture dut (
    .i_clk(clk), .i_rst(rst), .i_arm(arm), .i_abort(abort),
    .i_trig_mode(trig_mode), .i_trig_level(trig_level),
    .i_in_valid(in_valid), .i_in_data(in_data), .i_rd_ready(rd_ready),
    .o_rd_valid(rd_valid), .o_rd_data(rd_data), .o_rd_last(rd_last),
    .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model with the inputs currently driven, then clock the DUT.
  task automatic step();
    bit trig;
    if (rst) begin
      m_phase = 0; m_prev_vld = 0; exp_q.delete();
    end else if (abort) begin
      m_phase = 0; exp_q.delete();
    end else if (m_phase == 0 && arm) begin
      m_phase = 1; m_prev_vld = 0; exp_q.delete();
    end else if (m_phase == 1 && in_valid) begin
      if (trig_mode == 2'd1)      trig = m_prev_vld && (m_prev < trig_level) && (in_data >= trig_level);
      else if (trig_mode == 2'd2) trig = m_prev_vld && (m_prev >= trig_level) && (in_data < trig_level);
      else                        trig = 1;
      m_prev = in_data; m_prev_vld = 1;
      if (trig) begin
        exp_q.push_back(in_data); m_phase = 2;
      end
    end else if (m_phase == 2 && in_valid) begin
      exp_q.push_back(in_data);
      if (exp_q.size() == DEEP) m_phase = 3;
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_arm();
    arm = 1; step(); arm = 0;
  endtask

  task automatic feed(input logic [7:0] d);
    in_valid = 1; in_data = d; step(); in_valid = 0;
  endtask

  task automatic capture_run(input bit ramp, input bit gaps, input bit stray,
                             input bit jitter, input int stop_size);
    int n = 0;
    int r = 0;
    while ((m_phase == 1 || m_phase == 2) && exp_q.size() < stop_size && n < 5000) begin
      in_valid = gaps ? ($urandom_range(3) != 0) : 1'b1;
      in_data  = ramp ? 8'(r) : 8'($urandom);
      arm      = stray && ($urandom_range(15) == 0);
      if (jitter && m_phase == 1) trig_level = 8'($urandom_range(32, 224));
      if (in_valid) r++;
      step();
      n++;
    end
    in_valid = 0; arm = 0;
    check("busy_after_capture", {31'd0, busy}, 32'd1);
  endtask

  task automatic readout(input bit rand_rdy, input int stop_at,
                         output logic [7:0] g0, output logic [7:0] g1);
    int         cnt = 0, cyc = 0, lat = 0;
    bit         stalled = 0;
    logic [7:0] held = 8'h00;
    logic       held_last = 1'b0;
    g0 = 8'h00; g1 = 8'h00;
    rd_ready = 0;
    while (!rd_valid && lat < 10) begin
      step(); lat++;
    end
    check("rd_valid_latency_le2", {31'd0, lat <= 2}, 32'd1);
    while (cnt < DEEP && cyc < 20000 && cnt != stop_at) begin
      rd_ready = rand_rdy ? 1'($urandom_range(1)) : 1'b1;
      arm      = ($urandom_range(7) == 0);
      if (!rand_rdy) check("no_bubble", {31'd0, rd_valid}, 32'd1);
      if (stalled) begin
        check("stall_valid", {31'd0, rd_valid}, 32'd1);
        check("stall_data", {24'd0, rd_data}, {24'd0, held});
        check("stall_last", {31'd0, rd_last}, {31'd0, held_last});
      end
      stalled = rd_valid && !rd_ready;
      held = rd_data; held_last = rd_last;
      if (rd_valid && rd_ready) begin
        check("rd_data", {24'd0, rd_data}, {24'd0, exp_q[cnt]});
        check("rd_last", {31'd0, rd_last}, {31'd0, cnt == DEEP - 1});
        if (cnt == 0) g0 = rd_data;
        if (cnt == 1) g1 = rd_data;
        cnt++;
      end
      step();
      cyc++;
    end
    arm = 0; rd_ready = 0;
    if (stop_at < 0) begin
      check("transfers", cnt, DEEP);
      check("end_rd_valid", {31'd0, rd_valid}, 32'd0);
      check("done_pulse", {31'd0, done}, 32'd1);
      check("end_busy", {31'd0, busy}, 32'd0);
      m_phase = 0;
      step();
      check("done_one_cycle", {31'd0, done}, 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
    check({tag, "_rd_data"}, {24'd0, rd_data}, 32'd0);
    check({tag, "_rd_last"}, {31'd0, rd_last}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst = 1; arm = 0; abort = 0; in_valid = 0; in_data = 0; rd_ready = 0;
    trig_mode = 2'd0; trig_level = 8'h00;
    step(); step();
    rst = 0;
    check_reset_outputs("reset");

    // immediate mode ramp, continuous ready
    trig_mode = 2'd0;
    pulse_arm();
    check("busy_armed", {31'd0, busy}, 32'd1);
    capture_run(1, 0, 0, 0, DEEP);
    readout(0, -1, got0, got1);
    check("ramp_first", {24'd0, got0}, 32'h00);
    check("ramp_second", {24'd0, got1}, 32'h01);

    // rising edge at 0x80
    trig_mode = 2'd1; trig_level = 8'h80;
    pulse_arm();
    feed(8'h90); feed(8'h10); feed(8'h7F); feed(8'h80); feed(8'h81);
    capture_run(0, 1, 1, 0, DEEP);
    readout(1, -1, got0, got1);
    check("rise_first", {24'd0, got0}, 32'h80);
    check("rise_second", {24'd0, got1}, 32'h81);

    // falling edge at 0x40
    trig_mode = 2'd2; trig_level = 8'h40;
    pulse_arm();
    feed(8'h50); feed(8'h40); feed(8'h3F);
    capture_run(0, 1, 1, 0, DEEP);
    readout(1, -1, got0, got1);
    check("fall_first", {24'd0, got0}, 32'h3F);

    // mode 3 behaves as immediate
    trig_mode = 2'd3;
    pulse_arm();
    feed(8'hA5);
    capture_run(0, 1, 0, 0, DEEP);
    readout(1, -1, got0, got1);
    check("mode3_first", {24'd0, got0}, 32'hA5);

    // abort at sample 100, then re-arm with a threshold that moves while armed
    trig_mode = 2'd0;
    pulse_arm();
    capture_run(0, 1, 0, 0, 100);
    abort = 1; step(); abort = 0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    trig_mode = 2'd1;
    pulse_arm();
    capture_run(0, 1, 1, 1, DEEP);
    readout(1, -1, got0, got1);

    // reset at readout word 300, then a clean full capture
    trig_mode = 2'd0;
    pulse_arm();
    capture_run(0, 0, 0, 0, DEEP);
    readout(1, 300, got0, got1);
    rst = 1; step(); rst = 0;
    check_reset_outputs("midread_reset");
    trig_mode = 2'd2; trig_level = 8'h70;
    pulse_arm();
    capture_run(0, 1, 1, 0, DEEP);
    readout(0, -1, got0, got1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
